ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
Parametrised successor to the single-key scancode converter. Consumes a stream of complete PS/2 scan-code bytes from the receiver. Tracks E0 (extended) and F0 (break) prefixes and maps each code through a parameter table of NUM_KEYS entries. Emits one registered make/break event per mapped key and maintains a held-key bitmap for the display/blur control logic.

Parameters:
NUM_KEYS, 4, number of mapped keys (1..64)
ADDR_W, 3, width of o_keyAddr; must satisfy 2^ADDR_W > NUM_KEYS
KEY_CODES, 32'h75_1E_16_45, NUM_KEYS*8 bits; entry i in bits [8i+7:8i]
KEY_EXT, 4'b1000, NUM_KEYS bits; bit i=1 means entry i requires the E0 prefix
FILTER_REPEAT, 1, 1 = suppress typematic make events for a key already held
TIMEOUT_CYCLES, 100000, idle cycles after a prefix byte before the sequence is abandoned

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset; asynchronous, active-high
i_scanValid  in  1  one-cycle strobe; i_scanByte holds a complete received byte
i_scanByte  in  8  scan-code byte
o_keyValid  out  1  one-cycle event strobe
o_keyAddr  out  ADDR_W  key address: table index+1; 0 is never emitted with o_keyValid
o_keyMake  out  1  1=make (press), 0=break (release); qualified by o_keyValid
o_keyExt  out  1  event came from an E0-prefixed code
o_keyHeld  out  NUM_KEYS  bit i=1 while key i is pressed

Behaviour:
- Reset (async, i_rst=1): state=IDLE; timeout counter=0; o_keyValid=0; o_keyAddr=0; o_keyMake=0; o_keyExt=0; o_keyHeld=0. Reset mid-sequence discards any pending prefix.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions occur only on i_scanValid=1:
  - IDLE: E0->EXT; F0->BRK; other byte->lookup as make (ext=0), stay IDLE.
  - EXT: F0->EXT_BRK; E0->EXT; other byte->lookup as make (ext=1)->IDLE.
  - BRK: E0->EXT_BRK; F0->BRK; other byte->lookup as break (ext=0)->IDLE.
  - EXT_BRK: E0/F0->EXT_BRK; other byte->lookup as break (ext=1)->IDLE.
- Controller response bytes 00, AA, EE, FA, FE, FF received in IDLE are ignored: no event, state unchanged. In any prefix state they are treated as ordinary codes and go to lookup (no match by default).
- Lookup: entry i matches when byte==KEY_CODES[8i+:8] and ext==KEY_EXT[i]. If several entries match, the lowest index wins. No match: no event; FSM still returns to IDLE.
- Event timing: the byte accepted in cycle N produces o_keyValid=1 in cycle N+1 only. o_keyAddr/o_keyMake/o_keyExt update in cycle N+1 and hold their values until the next event. o_keyHeld[i] sets (make) or clears (break) in cycle N+1.
- Repeat filter: with FILTER_REPEAT=1, a make for a key whose held bit is already 1 generates no event; o_keyHeld is unchanged. With FILTER_REPEAT=0, every make generates an event.
- A break for a key that is not held still generates an event with o_keyMake=0; o_keyHeld stays 0.
- Timeout: in EXT/BRK/EXT_BRK, the counter increments each cycle without i_scanValid. On reaching TIMEOUT_CYCLES-1, FSM->IDLE with no event. The counter is cleared on every i_scanValid and whenever the FSM is in IDLE. Counter width is clog2(TIMEOUT_CYCLES+1).
- Back-to-back i_scanValid on consecutive cycles must be accepted without loss.

Test Plan:
- Reset, then byte 45 -> cycle+1: o_keyValid=1, o_keyAddr=1, o_keyMake=1, o_keyExt=0, o_keyHeld=4'b0001.
- Bytes F0, 45 -> single event: addr=1, make=0; o_keyHeld=0. No event on the F0 byte.
- Bytes E0,75 then E0,F0,75 -> event addr=4 make=1 ext=1 (o_keyHeld=4'b1000), then addr=4 make=0 ext=1 (o_keyHeld=0). Plain 75 without E0 -> no event.
- Bytes 16,16,16 with FILTER_REPEAT=1 -> exactly one event (addr=2). Rerun with FILTER_REPEAT=0 -> three events.
- Byte F0, then TIMEOUT_CYCLES idle cycles, then 1E -> make event addr=3 (prefix discarded). Bytes AA, FA in IDLE -> no events.
- Byte E0, assert i_rst, release, then byte 75 -> no event; all outputs read 0 immediately on reset assertion.

Source files
------------

// File: rtl/ps2_key_decoder_if.sv
// rtl/ps2_key_decoder_if.sv - scan-byte input and key-event output bundle for ps2_key_decoder
//
// Signals:
//   i_scanValid  one-cycle strobe, i_scanByte holds a complete received byte
//   i_scanByte   scan-code byte
//   o_keyValid   one-cycle event strobe
//   o_keyAddr    table index + 1 of the key that produced the event
//   o_keyMake    1 = make (press), 0 = break (release)
//   o_keyExt     event came from an E0-prefixed code
//   o_keyHeld    bit i set while key i is pressed
// Modports:
//   master  byte source / event sink (receiver side, testbench)
//   slave   the decoder
interface ps2_key_decoder_if #(
    parameter int NUM_KEYS = 4,
    parameter int ADDR_W   = 3
);
    logic                i_scanValid;
    logic [7:0]          i_scanByte;
    logic                o_keyValid;
    logic [ADDR_W-1:0]   o_keyAddr;
    logic                o_keyMake;
    logic                o_keyExt;
    logic [NUM_KEYS-1:0] o_keyHeld;

    modport master (
        output i_scanValid,
        output i_scanByte,
        input  o_keyValid,
        input  o_keyAddr,
        input  o_keyMake,
        input  o_keyExt,
        input  o_keyHeld
    );

    modport slave (
        input  i_scanValid,
        input  i_scanByte,
        output o_keyValid,
        output o_keyAddr,
        output o_keyMake,
        output o_keyExt,
        output o_keyHeld
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 scan-code to make/break key event decoder with held-key bitmap
//
// Ports:
//   i_clk  system clock
//   i_rst  asynchronous active-high reset
//   bus    ps2_key_decoder_if.slave: scan bytes in, key events and held bitmap out
module ps2_key_decoder #(
    parameter int                    NUM_KEYS       = 4,
    parameter int                    ADDR_W         = 3,
    parameter logic [NUM_KEYS*8-1:0] KEY_CODES      = 32'h75_1E_16_45,
    parameter logic [NUM_KEYS-1:0]   KEY_EXT        = 4'b1000,
    parameter int                    FILTER_REPEAT  = 1,
    parameter int                    TIMEOUT_CYCLES = 100000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    ps2_key_decoder_if.slave      bus
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    tmo_cnt;

    logic                key_valid;
    logic [ADDR_W-1:0]   key_addr;
    logic                key_make;
    logic                key_ext;
    logic [NUM_KEYS-1:0] key_held;

    logic                is_ext_state;
    logic                is_brk_state;
    logic                is_prefix;
    logic                is_resp;
    logic                hit;
    logic [NUM_KEYS-1:0] hit_vec;
    logic [ADDR_W-1:0]   hit_addr;
    logic                do_lookup;
    logic                already_held;
    logic                emit;

    // Lookup and event qualification for the byte currently on the bus.
    always_comb begin
        is_ext_state = (state == S_EXT) || (state == S_EXT_BRK);
        is_brk_state = (state == S_BRK) || (state == S_EXT_BRK);
        is_prefix    = (bus.i_scanByte == CODE_EXT) || (bus.i_scanByte == CODE_BRK);

        // Keyboard controller responses; only meaningful outside a prefix sequence.
        case (bus.i_scanByte)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_resp = 1'b1;
            default:                                   is_resp = 1'b0;
        endcase

        // First match wins, so duplicate table entries resolve to the lowest index.
        hit      = 1'b0;
        hit_vec  = '0;
        hit_addr = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (!hit && (bus.i_scanByte == KEY_CODES[8*i +: 8]) && (is_ext_state == KEY_EXT[i])) begin
                hit        = 1'b1;
                hit_vec[i] = 1'b1;
                hit_addr   = ADDR_W'(i + 1);
            end
        end

        do_lookup    = bus.i_scanValid && !is_prefix && !((state == S_IDLE) && is_resp);
        already_held = |(hit_vec & key_held);
        // Typematic repeats of a held key are dropped; breaks always report.
        emit         = do_lookup && hit &&
                       (is_brk_state || !((FILTER_REPEAT != 0) && already_held));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_IDLE;
            tmo_cnt   <= '0;
            key_valid <= 1'b0;
            key_addr  <= '0;
            key_make  <= 1'b0;
            key_ext   <= 1'b0;
            key_held  <= '0;
        end else begin
            key_valid <= 1'b0;

            if (bus.i_scanValid) begin
                tmo_cnt <= '0;

                unique case (state)
                    S_IDLE: begin
                        if (bus.i_scanByte == CODE_EXT) begin
                            state <= S_EXT;
                        end else if (bus.i_scanByte == CODE_BRK) begin
                            state <= S_BRK;
                        end
                    end
                    S_EXT: begin
                        if (bus.i_scanByte == CODE_BRK) begin
                            state <= S_EXT_BRK;
                        end else if (bus.i_scanByte == CODE_EXT) begin
                            state <= S_EXT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_BRK: begin
                        if (bus.i_scanByte == CODE_EXT) begin
                            state <= S_EXT_BRK;
                        end else if (bus.i_scanByte == CODE_BRK) begin
                            state <= S_BRK;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_EXT_BRK: begin
                        if (is_prefix) begin
                            state <= S_EXT_BRK;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase

                if (emit) begin
                    key_valid <= 1'b1;
                    key_addr  <= hit_addr;
                    key_make  <= !is_brk_state;
                    key_ext   <= is_ext_state;
                    if (is_brk_state) begin
                        key_held <= key_held & ~hit_vec;
                    end else begin
                        key_held <= key_held | hit_vec;
                    end
                end
            end else if (state != S_IDLE) begin
                // A prefix with no follow-up byte is abandoned silently.
                if (tmo_cnt == TMO_LAST) begin
                    state   <= S_IDLE;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    assign bus.o_keyValid = key_valid;
    assign bus.o_keyAddr  = key_addr;
    assign bus.o_keyMake  = key_make;
    assign bus.o_keyExt   = key_ext;
    assign bus.o_keyHeld  = key_held;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - scoreboard bench for ps2_key_decoder, repeat filter on and off
module tb_ps2_key_decoder;

    localparam int TMO = 20;

    typedef struct {
        logic [2:0] addr;
        logic       make;
        logic       ext;
        logic [3:0] held;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       scan_valid;
    logic [7:0] scan_byte;

    int n_checks;
    int n_errors;
    int ev_cnt[2];

    ev_t q_ev0[$];
    ev_t q_ev1[$];

    // Reference model state: index 0 = filter on, index 1 = filter off.
    logic [3:0] m_held[2];
    bit         m_ext[2];
    bit         m_brk[2];
    int         gap;

    logic [7:0] key_tab[4];
    bit         ext_tab[4];

    ps2_key_decoder_if #(.NUM_KEYS(4), .ADDR_W(3)) bus_f ();
    ps2_key_decoder_if #(.NUM_KEYS(4), .ADDR_W(3)) bus_n ();

    assign bus_f.i_scanValid = scan_valid;
    assign bus_f.i_scanByte  = scan_byte;
    assign bus_n.i_scanValid = scan_valid;
    assign bus_n.i_scanByte  = scan_byte;

    ps2_key_decoder #(
        .NUM_KEYS(4), .ADDR_W(3), .KEY_CODES(32'h75_1E_16_45), .KEY_EXT(4'b1000),
        .FILTER_REPEAT(1), .TIMEOUT_CYCLES(TMO)
    ) dut_f (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_f)
    );

    ps2_key_decoder #(
        .NUM_KEYS(4), .ADDR_W(3), .KEY_CODES(32'h75_1E_16_45), .KEY_EXT(4'b1000),
        .FILTER_REPEAT(0), .TIMEOUT_CYCLES(TMO)
    ) dut_n (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lookup(input logic [7:0] b, input bit ext);
        for (int i = 0; i < 4; i++) begin
            if (key_tab[i] == b && ext_tab[i] == ext) return i;
        end
        return -1;
    endfunction

    function automatic bit is_resp(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

    task automatic push_ev(input int d, input ev_t e);
        if (d == 0) q_ev0.push_back(e);
        else        q_ev1.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b);
        ev_t e;
        int  idx;
        for (int d = 0; d < 2; d++) begin
            if ((m_ext[d] || m_brk[d]) && gap >= TMO) begin
                m_ext[d] = 1'b0;
                m_brk[d] = 1'b0;
            end
            if (b == 8'hE0) begin
                m_ext[d] = 1'b1;
            end else if (b == 8'hF0) begin
                m_brk[d] = 1'b1;
            end else if (!m_ext[d] && !m_brk[d] && is_resp(b)) begin
                // ignored in idle
            end else begin
                idx = lookup(b, m_ext[d]);
                if (idx >= 0) begin
                    e.addr = 3'(idx + 1);
                    e.ext  = m_ext[d];
                    if (m_brk[d]) begin
                        m_held[d] = m_held[d] & ~(4'b0001 << idx);
                        e.make = 1'b0;
                        e.held = m_held[d];
                        push_ev(d, e);
                    end else if (!(d == 0 && m_held[d][idx])) begin
                        m_held[d] = m_held[d] | (4'b0001 << idx);
                        e.make = 1'b1;
                        e.held = m_held[d];
                        push_ev(d, e);
                    end
                end
                m_ext[d] = 1'b0;
                m_brk[d] = 1'b0;
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        model_byte(b);
        scan_valid = 1'b1;
        scan_byte  = b;
        @(posedge clk);
        #1;
        scan_valid = 1'b0;
        scan_byte  = 8'h00;
        gap = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
        gap += n;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_held[d] = 4'b0000;
            m_ext[d]  = 1'b0;
            m_brk[d]  = 1'b0;
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_f_valid"}, bus_f.o_keyValid, 0);
        check_eq({tag, "_f_addr"},  bus_f.o_keyAddr,  0);
        check_eq({tag, "_f_make"},  bus_f.o_keyMake,  0);
        check_eq({tag, "_f_ext"},   bus_f.o_keyExt,   0);
        check_eq({tag, "_f_held"},  bus_f.o_keyHeld,  0);
        check_eq({tag, "_n_valid"}, bus_n.o_keyValid, 0);
        check_eq({tag, "_n_held"},  bus_n.o_keyHeld,  0);
    endtask

    // Monitor: every event must match the head of its scoreboard queue.
    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            if (bus_f.o_keyValid) begin
                ev_cnt[0]++;
                if (q_ev0.size() == 0) begin
                    check_eq("f_spurious_event", bus_f.o_keyValid, 0);
                end else begin
                    e = q_ev0.pop_front();
                    check_eq("f_ev_addr", bus_f.o_keyAddr, e.addr);
                    check_eq("f_ev_make", bus_f.o_keyMake, e.make);
                    check_eq("f_ev_ext",  bus_f.o_keyExt,  e.ext);
                    check_eq("f_ev_held", bus_f.o_keyHeld, e.held);
                end
            end
            if (bus_n.o_keyValid) begin
                ev_cnt[1]++;
                if (q_ev1.size() == 0) begin
                    check_eq("n_spurious_event", bus_n.o_keyValid, 0);
                end else begin
                    e = q_ev1.pop_front();
                    check_eq("n_ev_addr", bus_n.o_keyAddr, e.addr);
                    check_eq("n_ev_make", bus_n.o_keyMake, e.make);
                    check_eq("n_ev_ext",  bus_n.o_keyExt,  e.ext);
                    check_eq("n_ev_held", bus_n.o_keyHeld, e.held);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        logic [7:0] rnd_tab[7];

        key_tab = '{8'h45, 8'h16, 8'h1E, 8'h75};
        ext_tab = '{1'b0, 1'b0, 1'b0, 1'b1};
        rnd_tab = '{8'h45, 8'h16, 8'h1E, 8'h75, 8'hE0, 8'hF0, 8'hAA};
        n_checks   = 0;
        n_errors   = 0;
        ev_cnt[0]  = 0;
        ev_cnt[1]  = 0;
        gap        = 0;
        scan_valid = 1'b0;
        scan_byte  = 8'h00;
        model_reset();

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst_hold");
        rst = 1'b0;
        idle(2);
        check_zero("rst_release");

        // Plain make.
        send(8'h45);
        idle(2);
        check_eq("make45_held", bus_f.o_keyHeld, 4'b0001);

        // Break with F0 prefix; outputs hold after the strobe.
        send(8'hF0);
        send(8'h45);
        idle(2);
        check_eq("brk45_held", bus_f.o_keyHeld, 4'b0000);
        check_eq("brk45_addr_hold", bus_f.o_keyAddr, 3'd1);
        check_eq("brk45_make_hold", bus_f.o_keyMake, 1'b0);

        // Extended key press/release, then unprefixed 75 which must not match.
        send(8'hE0);
        send(8'h75);
        idle(2);
        check_eq("ext75_held", bus_f.o_keyHeld, 4'b1000);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        idle(2);
        c0 = ev_cnt[0];
        send(8'h75);
        idle(3);
        check_eq("plain75_no_event", ev_cnt[0] - c0, 0);

        // Typematic repeat, back-to-back bytes.
        c0 = ev_cnt[0];
        c1 = ev_cnt[1];
        send(8'h16);
        send(8'h16);
        send(8'h16);
        idle(2);
        check_eq("repeat_filter_on_events",  ev_cnt[0] - c0, 1);
        check_eq("repeat_filter_off_events", ev_cnt[1] - c1, 3);
        check_eq("repeat_held", bus_n.o_keyHeld, 4'b0010);
        send(8'hF0);
        send(8'h16);
        idle(2);

        // Break of a key that is not held still reports.
        send(8'hF0);
        send(8'h1E);
        idle(2);

        // Abandoned prefix, then controller responses in idle.
        send(8'hF0);
        idle(TMO + 5);
        send(8'h1E);
        idle(2);
        check_eq("timeout_make_held", bus_f.o_keyHeld, 4'b0100);
        c0 = ev_cnt[0];
        send(8'hAA);
        send(8'hFA);
        idle(3);
        check_eq("resp_no_event", ev_cnt[0] - c0, 0);
        send(8'hF0);
        send(8'h1E);
        idle(2);

        // Mixed random traffic through the scoreboard.
        for (int k = 0; k < 60; k++) begin
            send(rnd_tab[$urandom_range(0, 6)]);
            idle($urandom_range(0, 2));
        end
        idle(TMO + 5);

        // Reset mid-sequence with a key held.
        send(8'h45);
        send(8'h45);
        idle(2);
        send(8'hE0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        c0 = ev_cnt[0];
        send(8'h75);
        idle(3);
        check_eq("rst_prefix_discard", ev_cnt[0] - c0, 0);

        check_eq("f_queue_empty", q_ev0.size(), 0);
        check_eq("n_queue_empty", q_ev1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
